// File: rtl/ex_advint_mul_div.sv
// ex_advint_mul_div: 64-bit multiply/divide stage of the advanced-integer execute unit.
// The result is combinational while enable is high. While enable is low, the
// outputs show the last result captured on an enabled clock edge.
module ex_advint_mul_div (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] in1,
    input  logic [63:0] in2,
    input  logic        enable,
    input  logic [2:0]  unit,
    input  logic [1:0]  op,
    output logic [63:0] out,
    output logic [63:0] out2
);

    logic         is_unsigned;
    logic [127:0] mul_a;
    logic [127:0] mul_b;
    logic [127:0] prod;

    logic         neg_a;
    logic         neg_b;
    logic [63:0]  mag_a;
    logic [63:0]  mag_b;
    logic         div_zero;
    logic [63:0]  div_b;
    logic [63:0]  q_mag;
    logic [63:0]  r_mag;
    logic [63:0]  quot;
    logic [63:0]  rem;

    logic [63:0]  r1;
    logic [63:0]  r2;
    logic [63:0]  hold1_q;
    logic [63:0]  hold2_q;

    // op[1] is reserved and intentionally ignored.
    logic         unused_op1;
    assign unused_op1  = op[1];
    assign is_unsigned = op[0];

    // Multiplier: extend both operands to 128 bits, keep the low 128 bits of the product.
    always_comb begin
        mul_a = is_unsigned ? {64'd0, in1} : {{64{in1[63]}}, in1};
        mul_b = is_unsigned ? {64'd0, in2} : {{64{in2[63]}}, in2};
        prod  = mul_a * mul_b;
    end

    // Divider: unsigned divide of magnitudes, then restore signs.
    // The overflow case (min / -1) falls out naturally: the magnitude 2^63
    // negates back to itself and the remainder is 0.
    always_comb begin
        neg_a    = ~is_unsigned & in1[63];
        neg_b    = ~is_unsigned & in2[63];
        mag_a    = neg_a ? (~in1 + 64'd1) : in1;
        mag_b    = neg_b ? (~in2 + 64'd1) : in2;
        div_zero = (in2 == 64'd0);
        // Divisor forced to 1 on divide-by-zero so the divider never sees 0.
        div_b    = div_zero ? 64'd1 : mag_b;
        q_mag    = mag_a / div_b;
        r_mag    = mag_a % div_b;
        quot     = (neg_a ^ neg_b) ? (~q_mag + 64'd1) : q_mag;
        rem      = neg_a ? (~r_mag + 64'd1) : r_mag;
    end

    // Sub-unit decode; reserved or unknown units yield zero.
    always_comb begin
        r1 = 64'd0;
        r2 = 64'd0;
        case (unit)
            3'b000: begin
                r1 = prod[63:0];
                r2 = prod[127:64];
            end
            3'b001: begin
                if (div_zero) begin
                    r1 = {64{1'b1}};
                    r2 = in1;
                end else begin
                    r1 = quot;
                    r2 = rem;
                end
            end
            default: begin
                r1 = 64'd0;
                r2 = 64'd0;
            end
        endcase
    end

    // Holding registers capture the result on every enabled edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold1_q <= 64'd0;
            hold2_q <= 64'd0;
        end else if (enable) begin
            hold1_q <= r1;
            hold2_q <= r2;
        end
    end

    // Output mux: live result while enabled, held result otherwise.
    always_comb begin
        out  = enable ? r1 : hold1_q;
        out2 = enable ? r2 : hold2_q;
    end

endmodule

// File: tb/tb_ex_advint_mul_div.sv
// Self-checking bench for ex_advint_mul_div: directed vector table, hand-written
// hold/reset sequences and a random sweep against a 128-bit reference.
module tb_ex_advint_mul_div;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] in1;
    logic [63:0] in2;
    logic        enable;
    logic [2:0]  unit;
    logic [1:0]  op;
    logic [63:0] out;
    logic [63:0] out2;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [2:0]  unit;
        logic [1:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] e1;
        logic [63:0] e2;
    } vec_t;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

    vec_t vecs[14];

    ex_advint_mul_div dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .in1    (in1),
        .in2    (in2),
        .enable (enable),
        .unit   (unit),
        .op     (op),
        .out    (out),
        .out2   (out2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] e1, input logic [63:0] e2);
        checks++;
        if (out !== e1 || out2 !== e2) begin
            failures++;
            $display("FAIL %s: got out=%h out2=%h, expected out=%h out2=%h",
                     name, out, out2, e1, e2);
        end
    endtask

    task automatic drive(input logic en, input logic [2:0] u, input logic [1:0] o,
                         input logic [63:0] a, input logic [63:0] b);
        enable = en;
        unit   = u;
        op     = o;
        in1    = a;
        in2    = b;
    endtask

    initial begin
        logic signed [63:0]  sa;
        logic signed [63:0]  sb;
        logic signed [127:0] sp;
        logic [127:0]        ua;
        logic [127:0]        ub;
        logic [127:0]        up;
        logic [63:0]         eq;
        logic [63:0]         er;
        logic [63:0]         ra;
        logic [63:0]         rb;
        logic [1:0]          rop;

        vecs[0]  = '{"mul_s_neg3x7",   3'b000, 2'b00, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7,
                     64'hFFFF_FFFF_FFFF_FFEB, ONES};
        vecs[1]  = '{"mul_u_max_sq",   3'b000, 2'b01, ONES, ONES,
                     64'd1, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[2]  = '{"div_s_neg7_2",   3'b001, 2'b00, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
                     64'hFFFF_FFFF_FFFF_FFFD, ONES};
        vecs[3]  = '{"div_u_100_7",    3'b001, 2'b01, 64'd100, 64'd7, 64'd14, 64'd2};
        vecs[4]  = '{"div_u_by_zero",  3'b001, 2'b01, 64'd42, 64'd0, ONES, 64'd42};
        vecs[5]  = '{"div_s_by_zero",  3'b001, 2'b00, 64'd42, 64'd0, ONES, 64'd42};
        vecs[6]  = '{"div_s_overflow", 3'b001, 2'b00, MINV, ONES, MINV, 64'd0};
        vecs[7]  = '{"reserved_101",   3'b101, 2'b01, 64'd123, 64'd456, 64'd0, 64'd0};
        vecs[8]  = '{"div_s_7_neg2",   3'b001, 2'b00, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE,
                     64'hFFFF_FFFF_FFFF_FFFD, 64'd1};
        vecs[9]  = '{"mul_s_op1_ign",  3'b000, 2'b10, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7,
                     64'hFFFF_FFFF_FFFF_FFEB, ONES};
        vecs[10] = '{"div_u_max_2",    3'b001, 2'b01, ONES, 64'd2,
                     64'h7FFF_FFFF_FFFF_FFFF, 64'd1};
        vecs[11] = '{"mul_s_min_sq",   3'b000, 2'b00, MINV, MINV,
                     64'd0, 64'h4000_0000_0000_0000};
        vecs[12] = '{"mul_u_min_x2",   3'b000, 2'b01, MINV, 64'd2, 64'd0, 64'd1};
        vecs[13] = '{"mul_s_m1_m1",    3'b000, 2'b00, ONES, ONES, 64'd1, 64'd0};

        // Reset hold.
        rst_n = 1'b0;
        drive(1'b0, 3'b000, 2'b00, 64'd5, 64'd6);
        #2;
        check("reset_out_zero", 64'd0, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("post_reset_idle", 64'd0, 64'd0);
        end

        // Directed vector table.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(1'b1, vecs[i].unit, vecs[i].op, vecs[i].a, vecs[i].b);
            #1;
            check(vecs[i].name, vecs[i].e1, vecs[i].e2);
        end

        // Hold behaviour: capture 100/7, then change operands with enable low.
        @(negedge clk);
        drive(1'b1, 3'b001, 2'b01, 64'd100, 64'd7);
        @(posedge clk);
        #1;
        drive(1'b0, 3'b001, 2'b01, 64'd9, 64'd3);
        #1;
        check("hold_after_disable", 64'd14, 64'd2);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("hold_stable", 64'd14, 64'd2);
        end
        enable = 1'b1;
        #1;
        check("reenable_9_3", 64'd3, 64'd0);
        @(posedge clk);
        #1;
        enable = 1'b0;
        #1;
        check("hold_9_3", 64'd3, 64'd0);

        // Reset asserted mid-operation with enable high.
        @(negedge clk);
        drive(1'b1, 3'b000, 2'b01, 64'd3, 64'd5);
        rst_n = 1'b0;
        #1;
        check("reset_enabled_comb", 64'd15, 64'd0);
        @(posedge clk);
        #1;
        enable = 1'b0;
        #1;
        check("reset_hold_zero", 64'd0, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("release_idle_zero", 64'd0, 64'd0);
        @(negedge clk);
        enable = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
        #1;
        check("capture_after_release", 64'd15, 64'd0);

        // Random sweep against a 128-bit reference model.
        for (int i = 0; i < 40; i++) begin
            ra  = {$urandom, $urandom};
            rb  = (i % 2 == 0) ? {$urandom, $urandom} : 64'($urandom_range(1, 1000));
            if (i % 4 == 3) rb = ~rb + 64'd1;
            rop = 2'($urandom_range(0, 3));
            @(negedge clk);
            if (i < 20) begin
                drive(1'b1, 3'b000, rop, ra, rb);
                if (rop[0]) begin
                    ua = 128'(ra);
                    ub = 128'(rb);
                    up = ua * ub;
                    #1;
                    check("rand_mul_u", up[63:0], up[127:64]);
                end else begin
                    sa = ra;
                    sb = rb;
                    sp = 128'(sa) * 128'(sb);
                    sp = $signed(sa) * $signed(sb) + 128'sd0;
                    #1;
                    check("rand_mul_s", sp[63:0], sp[127:64]);
                end
            end else begin
                if (rb == 64'd0) rb = 64'd3;
                drive(1'b1, 3'b001, rop, ra, rb);
                if (rop[0]) begin
                    eq = ra / rb;
                    er = ra % rb;
                end else begin
                    sa = ra;
                    sb = rb;
                    if (ra == MINV && rb == ONES) begin
                        eq = MINV;
                        er = 64'd0;
                    end else begin
                        eq = 64'(sa / sb);
                        er = 64'(sa % sb);
                    end
                end
                #1;
                check(rop[0] ? "rand_div_u" : "rand_div_s", eq, er);
                checks++;
                if (out * rb + out2 !== ra) begin
                    failures++;
                    $display("FAIL rand_div_invariant: got q*b+r=%h, expected %h",
                             out * rb + out2, ra);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
